hsst2ad_fifo: RTL and testbench



---
 rtl/hsst2ad_pkg.sv | 15 +
 rtl/hsst2ad_fifo_if.sv | 27 ++
 rtl/hsst2ad_ram.sv | 32 +++
 rtl/hsst2ad_fifo.sv | 59 +++++
 tb/tb_hsst2ad_fifo.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/hsst2ad_pkg.sv
// Shared sizing and thresholds for the HSST-to-AD byte FIFO.
package hsst2ad_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int DEPTH_WIDTH      = 8;
    localparam int DEPTH            = 1 << DEPTH_WIDTH;
    localparam int ALMOST_FULL_NUM  = 252;
    localparam int ALMOST_EMPTY_NUM = 4;

    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [DEPTH_WIDTH-1:0] ptr_t;
    // One extra bit so a full FIFO (256 words) is representable.
    typedef logic [DEPTH_WIDTH:0]   count_t;

endpackage

// File: rtl/hsst2ad_fifo_if.sv
// Write/read bundle between the HSST receive path, the FIFO and the AD interface logic.
interface hsst2ad_fifo_if;
    import hsst2ad_pkg::*;

    // wr_en/rd_en are requests; a request is taken on the clk edge only when the
    // matching ready-style flag (!wr_full / !rd_empty) is true in that same cycle,
    // otherwise it is silently dropped. rd_data is valid after the accepting edge.
    data_t wr_data;
    logic  wr_en;
    logic  wr_full;
    logic  almost_full;
    logic  rd_en;
    data_t rd_data;
    logic  rd_empty;
    logic  almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty
    );

endinterface

// File: rtl/hsst2ad_ram.sv
// Simple dual-port RAM: synchronous write, read-enable-gated registered read output.
module hsst2ad_ram
    import hsst2ad_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  ptr_t  wr_addr,
    input  data_t wr_data,
    input  logic  rd_en,
    input  ptr_t  rd_addr,
    output data_t rd_data
);

    // Storage is not reset; pointer reset in the parent makes old contents unreachable.
    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hsst2ad_fifo.sv
// Single-clock 256x8 FIFO; pointers, occupancy count, flag decode and accept gating.
module hsst2ad_fifo
    import hsst2ad_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    hsst2ad_fifo_if.slave bus
);

    ptr_t   wptr;
    ptr_t   rptr;
    count_t count;
    logic   wr_acc;
    logic   rd_acc;
    data_t  ram_rd_data;

    // Gating uses the current flags, so at full a read wins and at empty a write wins.
    assign wr_acc = bus.wr_en && !bus.wr_full;
    assign rd_acc = bus.rd_en && !bus.rd_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ptr_t'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + ptr_t'(1);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + count_t'(1);
                2'b01:   count <= count - count_t'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.wr_full      = (count == count_t'(DEPTH));
    assign bus.rd_empty     = (count == '0);
    assign bus.almost_full  = (count >= count_t'(ALMOST_FULL_NUM));
    assign bus.almost_empty = (count <= count_t'(ALMOST_EMPTY_NUM));

    hsst2ad_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wptr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rptr),
        .rd_data (ram_rd_data)
    );

    assign bus.rd_data = ram_rd_data;

endmodule

// File: tb/tb_hsst2ad_fifo.sv
// Randomised and directed bench for hsst2ad_fifo against a queue-based reference model.
module tb_hsst2ad_fifo;
    import hsst2ad_pkg::*;

    logic clk;
    logic rst;
    hsst2ad_fifo_if bus ();

    hsst2ad_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    // ---------------- scoreboard ----------------
    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [DATA_WIDTH-1:0] exp_rd;
    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        int occ;
        occ = exp_q.size();
        check("rd_data",      32'(bus.rd_data),      32'(exp_rd));
        check("rd_empty",     32'(bus.rd_empty),     32'(occ == 0));
        check("wr_full",      32'(bus.wr_full),      32'(occ == DEPTH));
        check("almost_full",  32'(bus.almost_full),  32'(occ >= ALMOST_FULL_NUM));
        check("almost_empty", 32'(bus.almost_empty), 32'(occ <= ALMOST_EMPTY_NUM));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst        = 1'b1;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q.delete();
        exp_rd = '0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of requests; the model decides acceptance from its own occupancy.
    task automatic drive_cycle(input logic wr, input logic [DATA_WIDTH-1:0] data, input logic rd);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        bus.wr_en   = wr;
        bus.wr_data = data;
        bus.rd_en   = rd;
        rd_ok = rd && (exp_q.size() > 0);
        wr_ok = wr && (exp_q.size() < DEPTH);
        if (rd_ok) exp_rd = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(data);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) drive_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, DATA_WIDTH'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        exp_rd      = '0;

        phase = "reset";
        do_reset(20);

        phase = "fill";
        for (int i = 0; i < 257; i++) drive_cycle(1'b1, DATA_WIDTH'(255 - i), 1'b0);
        check("fill_count", 32'(exp_q.size()), 32'd256);

        phase = "drain";
        for (int i = 0; i < 257; i++) begin
            drive_cycle(1'b0, '0, 1'b1);
            if (i < 256) check("drain_order", 32'(bus.rd_data), 32'(255 - i));
        end
        check("drain_hold", 32'(bus.rd_data), 32'h00);

        phase = "simul_mid";
        write_n(10);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, DATA_WIDTH'($urandom_range(0, 255)), 1'b1);
        read_n(11);

        phase = "simul_full";
        write_n(256);
        drive_cycle(1'b1, 8'hA5, 1'b1);
        check("full_simul_count", 32'(exp_q.size()), 32'd255);
        read_n(256);

        phase = "simul_empty";
        drive_cycle(1'b1, 8'h3C, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        check("empty_simul_data", 32'(bus.rd_data), 32'h3C);

        phase = "wrap";
        write_n(200);
        read_n(200);
        write_n(100);
        read_n(100);

        phase = "mid_reset";
        write_n(50);
        do_reset(1);
        drive_cycle(1'b1, 8'h77, 1'b0);
        drive_cycle(1'b0, '0, 1'b1);
        check("post_reset_data", 32'(bus.rd_data), 32'h77);
        drive_cycle(1'b0, '0, 1'b1);

        phase = "random_wr_heavy";
        for (int i = 0; i < 900; i++)
            drive_cycle(1'($urandom_range(0, 3) != 0), DATA_WIDTH'($urandom_range(0, 255)),
                        1'($urandom_range(0, 3) == 0));
        phase = "random_rd_heavy";
        for (int i = 0; i < 900; i++)
            drive_cycle(1'($urandom_range(0, 3) == 0), DATA_WIDTH'($urandom_range(0, 255)),
                        1'($urandom_range(0, 3) != 0));
        phase = "random_mixed";
        for (int i = 0; i < 1000; i++)
            drive_cycle(1'($urandom_range(0, 1)), DATA_WIDTH'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
